scrypt_romix_core: RTL and testbench

- Sequential implementation of the scrypt ROMix function (r=1, 1024-bit block, Salsa20/8 BlockMix) with an on-chip scratchpad of N blocks.
- Sits between the input PBKDF2-HMAC-SHA256 stage and the output PBKDF2 stage of a scrypt hashing core.
- Accepts one 1024-bit block per job and returns the mixed 1024-bit block.

---
 rtl/scrypt_romix_core.sv | 181 ++++++++++++++++++
 tb/tb_scrypt_romix_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/scrypt_romix_core.sv
// scrypt_romix_core: scrypt ROMix (r=1, Salsa20/8 BlockMix) with an N-block on-chip scratchpad.
// Optional build macro ROMIX_PBKDF_CTX_EN carries the PBKDF2 inner/outer pad states alongside each job.
module scrypt_romix_core #(
    parameter int N     = 1024,
    parameter int LOG2N = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    input  logic [1023:0] in,
    output logic [1023:0] out,
`ifdef ROMIX_PBKDF_CTX_EN
    input  logic [255:0]  ixor,
    input  logic [255:0]  oxor,
    output logic [255:0]  ixor_out,
    output logic [255:0]  oxor_out,
`endif
    output logic          ready,
    output logic          valid
);
    typedef logic [15:0][31:0] w16_t;
    typedef enum logic [2:0] {IDLE, WRITE, READ, MIX, DONE} state_t;

    state_t state, state_nx;
    w16_t x_lo, x_hi, s, base, sal_in, dr, y, in_lo, in_hi;
    logic [31:0][31:0] in_w, res;
    logic [2:0] c;
    logic xr, accept, bm, last_i, fin, we;
    logic [LOG2N-1:0] i, addr;
    logic [1023:0] rdata;
    logic [1023:0] mem [N];

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic w16_t qr(input w16_t v, input int p0, input int p1, input int p2, input int p3);
        w16_t t;
        t = v;
        t[p1] = t[p1] ^ rotl(t[p0] + t[p3], 7);
        t[p2] = t[p2] ^ rotl(t[p1] + t[p0], 9);
        t[p3] = t[p3] ^ rotl(t[p2] + t[p1], 13);
        t[p0] = t[p0] ^ rotl(t[p3] + t[p2], 18);
        return t;
    endfunction

    function automatic w16_t dround(input w16_t v);
        w16_t t;
        t = qr(v, 0, 4, 8, 12);
        t = qr(t, 5, 9, 13, 1);
        t = qr(t, 10, 14, 2, 6);
        t = qr(t, 15, 3, 7, 11);
        t = qr(t, 0, 1, 2, 3);
        t = qr(t, 5, 6, 7, 4);
        t = qr(t, 10, 11, 8, 9);
        t = qr(t, 15, 12, 13, 14);
        return t;
    endfunction

    assign in_w   = in;
    assign ready  = state == IDLE || state == DONE;
    assign valid  = state == DONE;
    assign accept = ready & init;
    assign bm     = state == WRITE || (state == MIX && !xr);
    assign last_i = i == LOG2N'(N - 1);
    assign fin    = state == MIX && bm && c == 3'd7 && last_i;
    // Both Salsa inputs (Y0 and Y1) reduce to the XOR of the two halves of X as it stands.
    assign base   = x_lo ^ x_hi;
    assign sal_in = c[1:0] == 2'd0 ? base : s;
    assign dr     = dround(sal_in);
    assign we     = state == WRITE && c == 3'd0;
    // Next MIX read address comes straight from the Y1 feed-forward so the data lands for the XOR cycle.
    assign addr   = state == WRITE ? i : state == READ ? x_hi[0][LOG2N-1:0] : y[0][LOG2N-1:0];

    // Byte/word reordering between the bus format and little-endian words, plus feed-forward add.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            y[k]       = dr[k] + base[k];
            in_lo[k]   = bswap(in_w[31-k]);
            in_hi[k]   = bswap(in_w[15-k]);
            res[31-k]  = bswap(x_lo[k]);
            res[15-k]  = bswap(y[k]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state: fill scratchpad, one read issue, mix loop, then hold result.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = init ? WRITE : state;
            WRITE:      state_nx = (c == 3'd7 && last_i) ? READ : WRITE;
            READ:       state_nx = MIX;
            MIX:        state_nx = fin ? DONE : MIX;
            default:    state_nx = IDLE;
        endcase
    end

    // Single-port scratchpad: write X at the start of each fill BlockMix, otherwise read.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= {x_hi, x_lo};
        else
            rdata <= mem[addr];
    end

    // Datapath: load, XOR with V[j], and one Salsa double-round per cycle through each BlockMix.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_lo <= '0;
            x_hi <= '0;
            s    <= '0;
            c    <= '0;
            xr   <= 1'b0;
            i    <= '0;
            out  <= '0;
        end else if (accept) begin
            x_lo <= in_lo;
            x_hi <= in_hi;
            c    <= '0;
            xr   <= 1'b0;
            i    <= '0;
        end else if (state == READ) begin
            xr <= 1'b1;
        end else if (state == MIX && xr) begin
            x_lo <= x_lo ^ rdata[511:0];
            x_hi <= x_hi ^ rdata[1023:512];
            xr   <= 1'b0;
        end else if (bm) begin
            c <= c + 3'd1;
            if (c[1:0] != 2'd3)
                s <= dr;
            else if (!c[2])
                x_lo <= y;
            else
                x_hi <= y;
            if (c == 3'd7) begin
                i  <= i + LOG2N'(1);
                xr <= state == MIX;
            end
            if (fin)
                out <= res;
        end
    end

`ifdef ROMIX_PBKDF_CTX_EN
    logic [255:0] ixor_r, oxor_r;

    // Pad states are captured with the job and surface together with its result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ixor_r   <= '0;
            oxor_r   <= '0;
            ixor_out <= '0;
            oxor_out <= '0;
        end else begin
            if (accept) begin
                ixor_r <= ixor;
                oxor_r <= oxor;
            end
            if (fin) begin
                ixor_out <= ixor_r;
                oxor_out <= oxor_r;
            end
        end
    end
`else
    // Without the pad context the core carries no PBKDF2 state.
`endif
endmodule

// File: tb/tb_scrypt_romix_core.sv
// tb_scrypt_romix_core: scoreboard bench for scrypt_romix_core at N=16 using the RFC 7914 ROMix vector.
module tb_scrypt_romix_core;
    localparam int N = 16;
    localparam int LOG2N = 4;
    localparam logic [1023:0] RFC_IN = {
        128'hf7ce0b653d2d72a4108cf5abe912ffdd, 128'h777616dbbb27a70e8204f3ae2d0f6fad,
        128'h89f68f4811d1e87bcc3bd7400a9ffd29, 128'h094f0184639574f39ae5a1315217bcd7,
        128'h894991447213bb226c25b54da86370fb, 128'hcd984380374666bb8ffcb5bf40c254b0,
        128'h67d27c51ce4ad5fed829c90b505a571b, 128'h7f4d1cad6a523cda770e67bceaaf7e89};
    localparam logic [1023:0] RFC_OUT = {
        128'h79ccc193629debca047f0b70604bf6b6, 128'h2ce3dd4a9626e355fafc6198e6ea2b46,
        128'hd58413673b99b029d665c357601fb426, 128'ha0b2f4bba200ee9f0a43d19b571a9c71,
        128'hef1142e65d5a266fddca832ce59faa7c, 128'hac0b9cf1be2bffca300d01ee387619c4,
        128'hae12fd4438f203a0e4e1c47ec314861f, 128'h4e9087cb33396a6873e8f9d2539a4b8e};
    localparam logic [1023:0] PAT = {8{128'h00112233445566778899aabbccddeeff}};

    logic clk = 0, reset_n = 0, init = 0, valid_q = 0;
    logic [1023:0] din = '0, dout;
    logic ready, valid;
    int checks = 0, failures = 0, cyc = 0;
    logic [1023:0] exp_q[$];
    int due_q[$];
`ifdef ROMIX_PBKDF_CTX_EN
    logic [255:0] ixor = {8{32'h12345678}}, oxor = {8{32'habcdef01}}, ixor_out, oxor_out;
`endif

    scrypt_romix_core #(.N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .in(din), .out(dout),
`ifdef ROMIX_PBKDF_CTX_EN
        .ixor(ixor), .oxor(oxor), .ixor_out(ixor_out), .oxor_out(oxor_out),
`endif
        .ready(ready), .valid(valid));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] bs(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [15:0][31:0] salsa8(input logic [15:0][31:0] b);
        logic [15:0][31:0] x;
        x = b;
        for (int r = 0; r < 8; r += 2) begin
            x[4]  ^= rl(x[0] + x[12], 7);   x[8]  ^= rl(x[4] + x[0], 9);
            x[12] ^= rl(x[8] + x[4], 13);   x[0]  ^= rl(x[12] + x[8], 18);
            x[9]  ^= rl(x[5] + x[1], 7);    x[13] ^= rl(x[9] + x[5], 9);
            x[1]  ^= rl(x[13] + x[9], 13);  x[5]  ^= rl(x[1] + x[13], 18);
            x[14] ^= rl(x[10] + x[6], 7);   x[2]  ^= rl(x[14] + x[10], 9);
            x[6]  ^= rl(x[2] + x[14], 13);  x[10] ^= rl(x[6] + x[2], 18);
            x[3]  ^= rl(x[15] + x[11], 7);  x[7]  ^= rl(x[3] + x[15], 9);
            x[11] ^= rl(x[7] + x[3], 13);   x[15] ^= rl(x[11] + x[7], 18);
            x[1]  ^= rl(x[0] + x[3], 7);    x[2]  ^= rl(x[1] + x[0], 9);
            x[3]  ^= rl(x[2] + x[1], 13);   x[0]  ^= rl(x[3] + x[2], 18);
            x[6]  ^= rl(x[5] + x[4], 7);    x[7]  ^= rl(x[6] + x[5], 9);
            x[4]  ^= rl(x[7] + x[6], 13);   x[5]  ^= rl(x[4] + x[7], 18);
            x[11] ^= rl(x[10] + x[9], 7);   x[8]  ^= rl(x[11] + x[10], 9);
            x[9]  ^= rl(x[8] + x[11], 13);  x[10] ^= rl(x[9] + x[8], 18);
            x[12] ^= rl(x[15] + x[14], 7);  x[13] ^= rl(x[12] + x[15], 9);
            x[14] ^= rl(x[13] + x[12], 13); x[15] ^= rl(x[14] + x[13], 18);
        end
        for (int k = 0; k < 16; k++) x[k] = x[k] + b[k];
        return x;
    endfunction

    function automatic logic [31:0][31:0] bmix(input logic [31:0][31:0] x);
        logic [15:0][31:0] y0, y1;
        y0 = salsa8(x[31:16] ^ x[15:0]);
        y1 = salsa8(y0 ^ x[31:16]);
        return {y1, y0};
    endfunction

    function automatic logic [1023:0] romix(input logic [1023:0] b);
        logic [31:0][31:0] x;
        logic [31:0][31:0] v [N];
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) x[k] = bs(b[1023-32*k -: 32]);
        for (int k = 0; k < N; k++) begin
            v[k] = x;
            x = bmix(x);
        end
        for (int k = 0; k < N; k++) begin
            x = x ^ v[int'(x[16][LOG2N-1:0])];
            x = bmix(x);
        end
        for (int k = 0; k < 32; k++) r[1023-32*k -: 32] = bs(x[k]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int k = 31; k >= 0; k--)
                if (act[32*k +: 32] !== exp[32*k +: 32]) begin
                    $display("FAIL %s: word %0d got %h expected %h", nm, 31 - k, act[32*k +: 32], exp[32*k +: 32]);
                    break;
                end
        end
    endtask

    always @(negedge clk) begin
        if (valid && !valid_q) begin
            if (exp_q.size() == 0)
                chk("spurious_valid", 1, 0);
            else begin
                chk("result", dout, exp_q.pop_front());
                chk("latency", cyc, due_q.pop_front());
            end
        end
        valid_q <= valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ready, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", valid, 1);
        @(negedge clk);
    endtask

    task automatic start(input logic [1023:0] v, input logic [1023:0] e, input bit push, input int hold);
        wait_ready();
        @(negedge clk);
        din = v;
        init = 1;
        @(posedge clk);
        #1;
        if (push) begin
            exp_q.push_back(e);
            due_q.push_back(cyc + 17 * N + 1);
        end
        chk("ready_drop", ready, 0);
        chk("valid_clear", valid, 0);
        repeat (hold) @(posedge clk);
        #1 init = 0;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_out", dout, 0);
`ifdef ROMIX_PBKDF_CTX_EN
        chk("rst_ixor_out", ixor_out, 0);
`endif
        @(negedge clk) reset_n = 1;
        start(RFC_IN, RFC_OUT, 1, 200);
`ifdef ROMIX_PBKDF_CTX_EN
        chk("oxor_out_busy", oxor_out, 0);
`endif
        wait_done();
`ifdef ROMIX_PBKDF_CTX_EN
        chk("ixor_out", ixor_out, ixor);
        chk("oxor_out", oxor_out, oxor);
`endif
        repeat (10) @(negedge clk);
        chk("valid_hold", valid, 1);
        chk("out_hold", dout, RFC_OUT);
        start('0, romix('0), 1, 0);
        wait_done();
        start(PAT, '0, 0, 0);
        repeat (8 * N) @(posedge clk);
        #1 reset_n = 0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_valid", valid, 0);
        chk("abort_out", dout, 0);
        @(negedge clk) reset_n = 1;
        start(PAT, romix(PAT), 1, 0);
        wait_done();
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
